// File: rtl/netcon_pkg.sv
// Shared types and constants for the netcon registered feed-through blocks.
package netcon_pkg;

   localparam int unsigned NETCON_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } netcon_state_e;

endpackage : netcon_pkg

// File: rtl/netcon_skid_buffer_if.sv
// Valid/ready handshake bundle for both sides of the skid buffer.
interface netcon_skid_buffer_if #(
   parameter int unsigned WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   // Environment view: drives the producer side and the consumer ready.
   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   // Buffer view.
   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

endinterface : netcon_skid_buffer_if

// File: rtl/netcon_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module netcon_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule : netcon_sat_counter

// File: rtl/netcon_skid_buffer.sv
// Two-entry registered valid/ready feed-through; no input-to-output combinational path.
// Optional stall statistics counter enabled by defining NETCON_SKID_STATS_EN.
module netcon_skid_buffer
   import netcon_pkg::*;
#(
   parameter int unsigned WIDTH = NETCON_DEFAULT_WIDTH,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   netcon_skid_buffer_if.slave  bus
`ifdef NETCON_SKID_STATS_EN
   ,
   output logic [CNT_W-1:0]     stall_cnt
`endif
);

   netcon_state_e    state_q;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             push;
   logic             pop;

   assign push = bus.in_valid & in_ready_q;
   assign pop  = out_valid_q & bus.out_ready;

   // Handshake flags are kept as their own flops so outputs never depend on inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (push) begin
                  main_q      <= bus.in_data;
                  state_q     <= ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ONE: begin
               if (push && pop) begin
                  main_q <= bus.in_data;
               end else if (push) begin
                  skid_q     <= bus.in_data;
                  state_q    <= FULL;
                  in_ready_q <= 1'b0;
               end else if (pop) begin
                  state_q     <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            FULL: begin
               if (pop) begin
                  main_q     <= skid_q;
                  state_q    <= ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_q;

`ifdef NETCON_SKID_STATS_EN
   logic stall;

   assign stall = out_valid_q & ~bus.out_ready;

   netcon_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall),
      .count (stall_cnt)
   );
`endif

endmodule : netcon_skid_buffer

// File: tb/tb_netcon_skid_buffer.sv
// Self-checking bench: queue-based occupancy model plus directed literal checks and random traffic.
module tb_netcon_skid_buffer;

   localparam int unsigned W = 8;
`ifdef NETCON_SKID_STATS_EN
   localparam int unsigned CW = 2;
`else
   localparam int unsigned CW = 16;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;
   bit   chk_en;

   logic [W-1:0] mq[$];
   int           stall_m;

   netcon_skid_buffer_if #(.WIDTH(W)) bus ();

`ifdef NETCON_SKID_STATS_EN
   logic [CW-1:0] stall_cnt;
`endif

   netcon_skid_buffer #(
      .WIDTH (W),
      .CNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave)
`ifdef NETCON_SKID_STATS_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a FIFO of capacity 2; one word in/out per edge, no handshake during reset.
   always @(posedge clk) begin : model_upd
      bit pu;
      bit po;
      if (rst) begin
         mq.delete();
         stall_m = 0;
      end else begin
         pu = bus.in_valid && (mq.size() < 2);
         po = bus.out_ready && (mq.size() > 0);
         if ((mq.size() > 0) && !bus.out_ready && (stall_m < (2 ** CW) - 1)) stall_m++;
         if (po) void'(mq.pop_front());
         if (pu) mq.push_back(bus.in_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
         check("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
         if (mq.size() > 0) check("out_data", 32'(bus.out_data), 32'(mq[0]));
`ifdef NETCON_SKID_STATS_EN
         check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
`endif
      end
   end

   task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      chk_en = 1'b0;
      rst    = 1'b1;
      drive(1'b1, 8'hA5, 1'b0);
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_data", 32'(bus.out_data), 32'h00);
      rst = 1'b0;
      drive(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);

      // Full-rate stream: each word visible one edge after its push.
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, W'(i), 1'b1);
         @(negedge clk);
         check("stream_data", 32'(bus.out_data), 32'(i));
         check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      end
      drive(1'b0, 8'h00, 1'b1);
      @(negedge clk);

      // Backpressure fills the skid slot; third word must be held by the producer.
      drive(1'b1, 8'h11, 1'b0);
      @(negedge clk);
      drive(1'b1, 8'h22, 1'b0);
      @(negedge clk);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 8'h33, 1'b0);
      @(negedge clk);
      check("bp_hold_11", 32'(bus.out_data), 32'h11);
      drive(1'b1, 8'h33, 1'b1);
      @(negedge clk);
      check("bp_out_22", 32'(bus.out_data), 32'h22);
      check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      check("bp_out_33", 32'(bus.out_data), 32'h33);
      drive(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      check("bp_drained", 32'(bus.out_valid), 32'd0);

      // Simultaneous push and pop in ONE replaces the word.
      drive(1'b1, 8'h44, 1'b0);
      @(negedge clk);
      check("pt_44", 32'(bus.out_data), 32'h44);
      drive(1'b1, 8'h55, 1'b1);
      @(negedge clk);
      check("pt_55", 32'(bus.out_data), 32'h55);
      check("pt_in_ready", 32'(bus.in_ready), 32'd1);
      check("pt_out_valid", 32'(bus.out_valid), 32'd1);
      drive(1'b0, 8'h00, 1'b1);
      @(negedge clk);

      // Reset while FULL discards both words.
      drive(1'b1, 8'h66, 1'b0);
      @(negedge clk);
      drive(1'b1, 8'h77, 1'b0);
      @(negedge clk);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      rst = 1'b0;
      drive(1'b1, 8'h88, 1'b0);
      @(negedge clk);
      check("after_rst_88", 32'(bus.out_data), 32'h88);
      drive(1'b0, 8'h00, 1'b0);

`ifdef NETCON_SKID_STATS_EN
      check("stall_start", 32'(stall_cnt), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_seq", 32'(stall_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      end
`endif

      // Random traffic with occasional reset, checked every cycle by the model.
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         drive(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 2) != 0));
         @(negedge clk);
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_netcon_skid_buffer
